// File: rtl/priority_arbiter_held_pkg.sv
// Shared constants for the held priority arbiter slice.
// Default sizing of eight requestors with a 3-bit index.
package priority_arbiter_held_pkg;

    localparam int DEFAULT_WORD_WIDTH  = 8;
    localparam int DEFAULT_INDEX_WIDTH = 3;

    // Smallest legal grant_index width for a given requestor count (never below 1).
    function automatic int min_index_width(input int word_width);
        int w;
        w = 1;
        while ((1 << w) < word_width) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/priority_arbiter_held_if.sv
// Request/grant bundle between requestors (master) and the held arbiter (slave).
interface priority_arbiter_held_if
    import priority_arbiter_held_pkg::*;
#(
    parameter int WORD_WIDTH  = DEFAULT_WORD_WIDTH,
    parameter int INDEX_WIDTH = DEFAULT_INDEX_WIDTH
);

    logic [WORD_WIDTH-1:0]  requests;
    logic [WORD_WIDTH-1:0]  grant;
    logic [INDEX_WIDTH-1:0] grant_index;
    logic                   grant_valid;
    logic                   grant_new;

    modport master (
        output requests,
        input  grant,
        input  grant_index,
        input  grant_valid,
        input  grant_new
    );

    modport slave (
        input  requests,
        output grant,
        output grant_index,
        output grant_valid,
        output grant_new
    );

endinterface

// File: rtl/priority_arbiter_held_isolate.sv
// Keeps only the rightmost set bit of a word; all zero in gives all zero out.
module bitmask_isolate_rightmost_1_bit #(
    parameter int WORD_WIDTH = 8
) (
    input  logic [WORD_WIDTH-1:0] word_in,
    output logic [WORD_WIDTH-1:0] word_out
);

    // Negation is WORD_WIDTH bits wide, so the carry out of the top bit is dropped.
    logic [WORD_WIDTH-1:0] negated;

    assign negated  = -word_in;
    assign word_out = word_in & negated;

endmodule

// File: rtl/priority_arbiter_held.sv
// Registered LSB-first priority arbiter: a granted requestor keeps the grant
// until it drops its request; there is no pre-emption.
module priority_arbiter_held
    import priority_arbiter_held_pkg::*;
#(
    parameter int WORD_WIDTH  = DEFAULT_WORD_WIDTH,
    parameter int INDEX_WIDTH = DEFAULT_INDEX_WIDTH
) (
    input  logic                   clock,
    input  logic                   clear,
    priority_arbiter_held_if.slave arb
);

    logic [WORD_WIDTH-1:0]  candidate;
    logic [WORD_WIDTH-1:0]  grant_reg;
    logic [WORD_WIDTH-1:0]  grant_next;
    logic [INDEX_WIDTH-1:0] grant_index_reg;
    logic [INDEX_WIDTH-1:0] grant_index_next;
    logic                   grant_valid_reg;
    logic                   grant_valid_next;
    logic                   grant_new_reg;
    logic                   grant_new_next;
    logic                   held;

    bitmask_isolate_rightmost_1_bit #(
        .WORD_WIDTH (WORD_WIDTH)
    ) u_isolate (
        .word_in  (arb.requests),
        .word_out (candidate)
    );

    assign held       = |(grant_reg & arb.requests);
    assign grant_next = held ? grant_reg : candidate;

    // Index bit gi is the OR of every grant_next bit whose position has bit gi set.
    for (genvar gi = 0; gi < INDEX_WIDTH; gi++) begin : g_encode
        logic [WORD_WIDTH-1:0] select;
        for (genvar gj = 0; gj < WORD_WIDTH; gj++) begin : g_select
            assign select[gj] = 1'((gj >> gi) & 1);
        end
        assign grant_index_next[gi] = |(grant_next & select);
    end

    assign grant_valid_next = |grant_next;
    // Re-granting the same requestor without a gap counts as one grant.
    assign grant_new_next   = grant_valid_next && (grant_next != grant_reg);

    always_ff @(posedge clock) begin
        if (clear) begin
            grant_reg       <= '0;
            grant_index_reg <= '0;
            grant_valid_reg <= 1'b0;
            grant_new_reg   <= 1'b0;
        end else begin
            grant_reg       <= grant_next;
            grant_index_reg <= grant_index_next;
            grant_valid_reg <= grant_valid_next;
            grant_new_reg   <= grant_new_next;
        end
    end

    assign arb.grant       = grant_reg;
    assign arb.grant_index = grant_index_reg;
    assign arb.grant_valid = grant_valid_reg;
    assign arb.grant_new   = grant_new_reg;

endmodule
